// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode CSR file with trap state and counters (CSR_COUNTERS_EN)
// Write-back responder with same-cycle read bypass; trap_req > mret > csr_wben.
module csr_file #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        csr_wben,
  input  logic [11:0] csr_wbaddr,
  input  logic [31:0] csr_wbdata,
  input  logic        instr_retire,
  input  logic        trap_req,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_tval,
  input  logic        mret,
  output logic [31:0] trap_vector,
  output logic [31:0] mepc_out,
  output logic        irq_enable
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic [31:0] r_mie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;

  logic        w_wr;
  logic        w_wr_ok;
  logic [31:0] w_mstatus;
  logic [31:0] w_rdata;
  logic        w_illegal;

  // A software write only lands when neither a trap nor an mret claims the cycle.
  assign w_wr      = csr_wben & ~trap_req & ~mret;
  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};

  always_comb begin
    w_wr_ok = 1'b0;
    case (csr_wbaddr)
      A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH,
      A_MEPC, A_MCAUSE, A_MTVAL:             w_wr_ok = 1'b1;
`ifdef CSR_COUNTERS_EN
      A_MCYCLE, A_MINSTRET, A_MCYCLEH,
      A_MINSTRETH:                           w_wr_ok = 1'b1;
`endif
      default:                               w_wr_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= 32'h0;
      r_mtvec        <= RESET_MTVEC;
      r_mscratch     <= 32'h0;
      r_mepc         <= 32'h0;
      r_mcause       <= 32'h0;
      r_mtval        <= 32'h0;
    end else if (trap_req) begin
      r_mepc         <= trap_pc & ~32'h3;
      r_mcause       <= trap_cause;
      r_mtval        <= trap_tval;
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
    end else if (mret) begin
      r_mstatus_mie  <= r_mstatus_mpie;
      r_mstatus_mpie <= 1'b1;
    end else if (w_wr) begin
      case (csr_wbaddr)
        A_MSTATUS: begin
          r_mstatus_mie  <= csr_wbdata[3];
          r_mstatus_mpie <= csr_wbdata[7];
        end
        A_MIE:      r_mie      <= csr_wbdata;
        A_MTVEC:    r_mtvec    <= csr_wbdata & ~32'h3;
        A_MSCRATCH: r_mscratch <= csr_wbdata;
        A_MEPC:     r_mepc     <= csr_wbdata & ~32'h3;
        A_MCAUSE:   r_mcause   <= csr_wbdata;
        A_MTVAL:    r_mtval    <= csr_wbdata;
        default:    ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;

  // A written half replaces that half and the counter skips its increment.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mcycle   <= 64'h0;
      r_minstret <= 64'h0;
    end else begin
      if (w_wr && csr_wbaddr == A_MCYCLE)         r_mcycle[31:0]    <= csr_wbdata;
      else if (w_wr && csr_wbaddr == A_MCYCLEH)   r_mcycle[63:32]   <= csr_wbdata;
      else                                        r_mcycle          <= r_mcycle + 64'd1;
      if (w_wr && csr_wbaddr == A_MINSTRET)       r_minstret[31:0]  <= csr_wbdata;
      else if (w_wr && csr_wbaddr == A_MINSTRETH) r_minstret[63:32] <= csr_wbdata;
      else                                        r_minstret        <= r_minstret + {63'h0, instr_retire};
    end
  end
`else
  logic w_unused;
  assign w_unused = instr_retire;
`endif

  always_comb begin
    w_rdata   = 32'h0;
    w_illegal = 1'b0;
    case (csr_raddr)
      A_MSTATUS:  w_rdata = w_mstatus;
      A_MISA:     w_rdata = MISA_VAL;
      A_MIE:      w_rdata = r_mie;
      A_MTVEC:    w_rdata = r_mtvec;
      A_MSCRATCH: w_rdata = r_mscratch;
      A_MEPC:     w_rdata = r_mepc;
      A_MCAUSE:   w_rdata = r_mcause;
      A_MTVAL:    w_rdata = r_mtval;
      A_MHARTID:  w_rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
      A_MCYCLE,    A_CYCLE:    w_rdata = r_mcycle[31:0];
      A_MCYCLEH,   A_CYCLEH:   w_rdata = r_mcycle[63:32];
      A_MINSTRET,  A_INSTRET:  w_rdata = r_minstret[31:0];
      A_MINSTRETH, A_INSTRETH: w_rdata = r_minstret[63:32];
`else
      A_MCYCLE, A_CYCLE, A_MCYCLEH, A_CYCLEH,
      A_MINSTRET, A_INSTRET, A_MINSTRETH, A_INSTRETH: w_rdata = 32'h0;
`endif
      default:    w_illegal = 1'b1;
    endcase
    if (csr_wben && w_wr_ok && csr_wbaddr == csr_raddr)
      w_rdata = csr_wbdata;
  end

  assign csr_rdata   = w_rdata;
  assign csr_illegal = w_illegal;
  assign trap_vector = r_mtvec & ~32'h3;
  assign mepc_out    = r_mepc & ~32'h3;
  assign irq_enable  = r_mstatus_mie;

endmodule

// File: tb/tb_csr_file.sv
// tb/tb_csr_file.sv - directed vector bench for csr_file
// Counter checks depend on CSR_COUNTERS_EN matching the RTL build.
module tb_csr_file;

  logic        clk;
  logic        rst;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        csr_wben;
  logic [11:0] csr_wbaddr;
  logic [31:0] csr_wbdata;
  logic        instr_retire;
  logic        trap_req;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic [31:0] trap_tval;
  logic        mret;
  logic [31:0] trap_vector;
  logic [31:0] mepc_out;
  logic        irq_enable;

  int n_checks = 0;
  int n_fail   = 0;

  csr_file #(
    .RESET_MTVEC(32'h8000_0103),
    .HART_ID    (32'h0000_0005),
    .MISA_VAL   (32'h4000_0100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .csr_raddr   (csr_raddr),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal),
    .csr_wben    (csr_wben),
    .csr_wbaddr  (csr_wbaddr),
    .csr_wbdata  (csr_wbdata),
    .instr_retire(instr_retire),
    .trap_req    (trap_req),
    .trap_pc     (trap_pc),
    .trap_cause  (trap_cause),
    .trap_tval   (trap_tval),
    .mret        (mret),
    .trap_vector (trap_vector),
    .mepc_out    (mepc_out),
    .irq_enable  (irq_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wben;
    logic [11:0] wbaddr;
    logic [31:0] wbdata;
    logic [11:0] raddr;
    logic [31:0] exp_rdata;
    logic        exp_ill;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
    csr_raddr = addr;
    #1;
    check(name, csr_rdata, exp);
    check({name, "_ill"}, {31'h0, csr_illegal}, 32'h0);
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    csr_wben   = 1'b1;
    csr_wbaddr = addr;
    csr_wbdata = data;
    tick();
    csr_wben   = 1'b0;
  endtask

  initial begin
    rst = 1'b0; csr_raddr = 12'h0; csr_wben = 1'b0; csr_wbaddr = 12'h0; csr_wbdata = 32'h0;
    instr_retire = 1'b0; trap_req = 1'b0; trap_pc = 32'h0; trap_cause = 32'h0;
    trap_tval = 32'h0; mret = 1'b0;

    vecs[0]  = '{1'b0, 12'h000, 32'h0,         12'h300, 32'h0000_1800, 1'b0};
    vecs[1]  = '{1'b0, 12'h000, 32'h0,         12'h305, 32'h8000_0103, 1'b0};
    vecs[2]  = '{1'b0, 12'h000, 32'h0,         12'hF14, 32'h0000_0005, 1'b0};
    vecs[3]  = '{1'b0, 12'h000, 32'h0,         12'h301, 32'h4000_0100, 1'b0};
    vecs[4]  = '{1'b0, 12'h000, 32'h0,         12'h7C0, 32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b0, 12'h000, 32'h0,         12'h341, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b1, 12'h340, 32'hDEAD_BEEF, 12'h340, 32'hDEAD_BEEF, 1'b0};
    vecs[7]  = '{1'b0, 12'h000, 32'h0,         12'h340, 32'hDEAD_BEEF, 1'b0};
    vecs[8]  = '{1'b1, 12'h341, 32'h0000_1237, 12'h341, 32'h0000_1237, 1'b0};
    vecs[9]  = '{1'b0, 12'h000, 32'h0,         12'h341, 32'h0000_1234, 1'b0};
    vecs[10] = '{1'b1, 12'h305, 32'h0000_2003, 12'h300, 32'h0000_1800, 1'b0};
    vecs[11] = '{1'b0, 12'h000, 32'h0,         12'h305, 32'h0000_2000, 1'b0};
    vecs[12] = '{1'b1, 12'h301, 32'h1234_5678, 12'h301, 32'h4000_0100, 1'b0};
    vecs[13] = '{1'b0, 12'h000, 32'h0,         12'h301, 32'h4000_0100, 1'b0};
    vecs[14] = '{1'b1, 12'h7C0, 32'h1111_1111, 12'h7C0, 32'h0000_0000, 1'b1};
    vecs[15] = '{1'b1, 12'h304, 32'h0000_0888, 12'h304, 32'h0000_0888, 1'b0};
    vecs[16] = '{1'b0, 12'h000, 32'h0,         12'h304, 32'h0000_0888, 1'b0};
    vecs[17] = '{1'b1, 12'h300, 32'hFFFF_FFFF, 12'h343, 32'h0000_0000, 1'b0};
    vecs[18] = '{1'b0, 12'h000, 32'h0,         12'h300, 32'h0000_1888, 1'b0};
    vecs[19] = '{1'b1, 12'h300, 32'h0000_0000, 12'h342, 32'h0000_0000, 1'b0};
    vecs[20] = '{1'b0, 12'h000, 32'h0,         12'h300, 32'h0000_1800, 1'b0};
    vecs[21] = '{1'b0, 12'h000, 32'h0,         12'hC82, 32'h0000_0000, 1'b0};

    tick(); tick();
    rst = 1'b1;
    check("rst_trap_vector", trap_vector, 32'h8000_0100);
    check("rst_mepc_out", mepc_out, 32'h0);
    check("rst_irq_enable", {31'h0, irq_enable}, 32'h0);

    for (int i = 0; i < NV; i++) begin
      csr_wben   = vecs[i].wben;
      csr_wbaddr = vecs[i].wbaddr;
      csr_wbdata = vecs[i].wbdata;
      csr_raddr  = vecs[i].raddr;
      #1;
      check($sformatf("vec%0d_rdata", i), csr_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_ill", i), {31'h0, csr_illegal}, {31'h0, vecs[i].exp_ill});
      tick();
      csr_wben = 1'b0;
    end
    check("mtvec_trap_vector", trap_vector, 32'h0000_2000);

    // Trap entry then mret.
    wr(12'h300, 32'h0000_0008);
    check("mie_set_irq", {31'h0, irq_enable}, 32'h1);
    rd("mstatus_mie", 12'h300, 32'h0000_1808);
    trap_req = 1'b1; trap_pc = 32'h0000_0104; trap_cause = 32'h0000_000B; trap_tval = 32'h0000_0055;
    tick();
    trap_req = 1'b0;
    rd("trap_mepc", 12'h341, 32'h0000_0104);
    rd("trap_mcause", 12'h342, 32'h0000_000B);
    rd("trap_mtval", 12'h343, 32'h0000_0055);
    rd("trap_mstatus", 12'h300, 32'h0000_1880);
    check("trap_irq", {31'h0, irq_enable}, 32'h0);
    check("trap_mepc_out", mepc_out, 32'h0000_0104);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    rd("mret_mstatus", 12'h300, 32'h0000_1888);
    check("mret_irq", {31'h0, irq_enable}, 32'h1);

    // trap_req, mret and a write together: only the trap lands.
    trap_req = 1'b1; mret = 1'b1; trap_pc = 32'h0000_0208; trap_cause = 32'h0000_0002; trap_tval = 32'h0;
    csr_wben = 1'b1; csr_wbaddr = 12'h340; csr_wbdata = 32'h1111_1111;
    tick();
    trap_req = 1'b0; mret = 1'b0; csr_wben = 1'b0;
    rd("prio_mscratch", 12'h340, 32'hDEAD_BEEF);
    rd("prio_mepc", 12'h341, 32'h0000_0208);
    rd("prio_mcause", 12'h342, 32'h0000_0002);
    rd("prio_mstatus", 12'h300, 32'h0000_1880);

    // mret with a write: write dropped.
    mret = 1'b1; csr_wben = 1'b1; csr_wbaddr = 12'h343; csr_wbdata = 32'h7777_7777;
    tick();
    mret = 1'b0; csr_wben = 1'b0;
    rd("mret_drop_mtval", 12'h343, 32'h0);
    rd("mret2_mstatus", 12'h300, 32'h0000_1888);

`ifdef CSR_COUNTERS_EN
    csr_raddr = 12'hB00; csr_wben = 1'b1; csr_wbaddr = 12'hB00; csr_wbdata = 32'hFFFF_FFFE;
    #1;
    check("mcycle_bypass", csr_rdata, 32'hFFFF_FFFE);
    tick();
    csr_wben = 1'b0;
    rd("mcycle_w0", 12'hB00, 32'hFFFF_FFFE);
    rd("mcycleh_w0", 12'hB80, 32'h0);
    tick();
    rd("mcycle_w1", 12'hB00, 32'hFFFF_FFFF);
    tick();
    rd("mcycle_w2", 12'hB00, 32'h0);
    rd("mcycleh_w2", 12'hB80, 32'h1);
    rd("cycleh_alias", 12'hC80, 32'h1);

    wr(12'hB02, 32'h0);
    for (int i = 0; i < 8; i++) begin
      instr_retire = (i == 0 || i == 2 || i == 4 || i == 5 || i == 7);
      tick();
    end
    instr_retire = 1'b0;
    rd("minstret_5", 12'hB02, 32'h5);
    rd("instret_alias", 12'hC02, 32'h5);
    instr_retire = 1'b1;
    wr(12'hB82, 32'h0000_0007);
    instr_retire = 1'b0;
    rd("minstreth_w", 12'hB82, 32'h7);
    rd("minstret_hold", 12'hB02, 32'h5);

    wr(12'hB00, 32'd99);
    tick();
    rd("mcycle_100", 12'hB00, 32'd100);
    rd("mcycleh_hold", 12'hB80, 32'h1);
`else
    rd("nocnt_mcycle", 12'hB00, 32'h0);
    csr_raddr = 12'hB00; csr_wben = 1'b1; csr_wbaddr = 12'hB00; csr_wbdata = 32'h0000_0005;
    #1;
    check("nocnt_no_bypass", csr_rdata, 32'h0);
    tick();
    csr_wben = 1'b0;
    rd("nocnt_after_wr", 12'hB00, 32'h0);
    rd("nocnt_cycleh", 12'hC80, 32'h0);
`endif

    // One-cycle reset with a trap and write pending: reset wins.
    rst = 1'b0; trap_req = 1'b1; trap_pc = 32'h0000_0300; csr_wben = 1'b1;
    csr_wbaddr = 12'h340; csr_wbdata = 32'h2222_2222;
    tick();
    rst = 1'b1; trap_req = 1'b0; csr_wben = 1'b0;
    rd("rst2_mstatus", 12'h300, 32'h0000_1800);
    rd("rst2_mtvec", 12'h305, 32'h8000_0103);
    rd("rst2_mscratch", 12'h340, 32'h0);
    rd("rst2_mepc", 12'h341, 32'h0);
    rd("rst2_mie", 12'h304, 32'h0);
    rd("rst2_mcycle", 12'hB00, 32'h0);
    rd("rst2_minstreth", 12'hB82, 32'h0);
    check("rst2_trap_vector", trap_vector, 32'h8000_0100);
    check("rst2_mepc_out", mepc_out, 32'h0);
    check("rst2_irq", {31'h0, irq_enable}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR storage for the RV32 core.
- Is the responder for the CSR write-back bus that the register writeback stage drives (csr_wben/csr_wbaddr/csr_wbdata).
- Supplies CSR read data back to the pipeline, which routes it to rd.
- Also holds trap state (mepc/mcause/mtval/mstatus), trap vector, mret return PC, and the mcycle/minstret counters.

Parameters:
- RESET_MTVEC, 32'h0000_0000, reset value of mtvec.
- HART_ID, 0, value returned by mhartid.
- MISA_VAL, 32'h4000_0100, read-only misa value (RV32I).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- csr_raddr  in  12  read address.
- csr_rdata  out  32  combinational read data.
- csr_illegal  out  1  csr_raddr is unimplemented (combinational).
- csr_wben  in  1  write-back enable from writeback stage.
- csr_wbaddr  in  12  write-back address.
- csr_wbdata  in  32  write-back data (already merged for CSRRS/CSRRC by the pipeline).
- instr_retire  in  1  one instruction retired this cycle.
- trap_req  in  1  take trap this cycle.
- trap_pc  in  32  PC of trapping instruction.
- trap_cause  in  32  mcause value.
- trap_tval  in  32  mtval value.
- mret  in  1  mret retiring this cycle.
- trap_vector  out  32  mtvec with bits[1:0] forced 0.
- mepc_out  out  32  current mepc, bits[1:0] forced 0.
- irq_enable  out  1  mstatus.MIE.

Behaviour:
- Implemented addresses:
  - mstatus 0x300; misa 0x301 (RO); mie 0x304; mtvec 0x305; mscratch 0x340; mepc 0x341; mcause 0x342; mtval 0x343.
  - mcycle 0xB00; minstret 0xB02; mcycleh 0xB80; minstreth 0xB82.
  - cycle/instret read-only aliases 0xC00/0xC02/0xC80/0xC82; mhartid 0xF14 (RO).
  - Any other address: csr_rdata=0, csr_illegal=1.
- mstatus fields:
  - Only MIE[3], MPIE[7] are writable.
  - MPP[12:11] reads 2'b11 always; all other bits read 0.
- Reset (rst==0 at posedge):
  - mstatus MIE=0, MPIE=0 (reads 32'h0000_1800).
  - mtvec=RESET_MTVEC; all other writable CSRs and counters = 0.
  - Reset overrides every other input in that cycle.
  - Reset mid-trap or mid-write simply clears; no partial update.
- Outputs trap_vector, mepc_out and irq_enable follow registers; after reset they read RESET_MTVEC&~3, 0, 0.
- Write:
  - On posedge with csr_wben=1, the addressed writable CSR takes csr_wbdata next cycle.
  - Writes to RO or unimplemented addresses are ignored silently.
- Read bypass: if csr_wben=1 and csr_wbaddr==csr_raddr (writable address), csr_rdata returns csr_wbdata in the same cycle. Same rule as the GPR file's write-first forwarding.
- Counters (64-bit each):
  - mcycle += 1 every non-reset cycle.
  - minstret += instr_retire.
  - Carry propagates low→high half.
  - Software write to a half replaces that half that cycle and suppresses that counter's increment for the cycle; the other half holds.
  - 0xFFFF_FFFF wraps to 0 with carry into high; full 64-bit wrap to 0.
- Priority in one cycle: trap_req > mret > csr_wben.
  - trap_req=1:
    - mepc<=trap_pc, mcause<=trap_cause, mtval<=trap_tval.
    - MPIE<=MIE, MIE<=0.
    - Any simultaneous CSR write or mret is dropped.
  - mret=1 (no trap): MIE<=MPIE, MPIE<=1; simultaneous CSR write dropped.
  - Counters still advance during trap/mret cycles. instr_retire is honoured even with a trap.
- mepc write ignores bits[1:0] (stored as 0). mtvec direct mode only; bits[1:0] stored as 0.

Optional Feature:
- CSR_COUNTERS_EN defined: mcycle/minstret(h) and aliases implemented as above.
- Undefined:
  - Counter addresses stay legal (csr_illegal=0) but read 0.
  - Writes to them are ignored; no counter flops are synthesised.

Test Plan:
- Reset then read 0x300, 0x305, 0xF14 → 32'h0000_1800, RESET_MTVEC, HART_ID. Read 0x7C0 → rdata 0, illegal 1.
- wben=1, wbaddr=0x340, wbdata=32'hDEAD_BEEF, raddr=0x340 same cycle → rdata DEAD_BEEF (bypass); next cycle without wben → still DEAD_BEEF.
- Write mstatus 32'h0000_0008 (MIE=1), then trap_req with pc 32'h0000_0104, cause 32'h0000_000B:
  - mepc=0x104, mcause=0xB, mstatus=0x1880, irq_enable=0.
  - Then mret → mstatus=0x1888, irq_enable=1.
- Write mcycle=32'hFFFF_FFFE:
  - Next cycles read FFFF_FFFF, then 0000_0000 with mcycleh=1.
  - minstret counts exactly the number of instr_retire pulses (e.g. 5 of 8 cycles → 5).
- Same cycle trap_req=1, mret=1, wben to mscratch → only trap effects; mscratch unchanged.
- Assert rst=0 for one cycle mid-count (mcycle=100) → all CSRs back to reset values. Build without CSR_COUNTERS_EN → 0xB00 reads 0, illegal 0.
